// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - tick-paced control FSM sequencing one N x N matrix product C = A x B
module matmul_sequencer #(
    parameter int N      = 4,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, WRITE} state_t;

    state_t        state;
    logic [CW-1:0] i, j, k;
    logic [CW-1:0] i_inc, j_inc, k_inc;

    assign i_inc = i + CW'(1);
    assign j_inc = j + CW'(1);
    assign k_inc = k + CW'(1);

    // row*N+col never exceeds N*N-1, so ADDR_W bits always suffice
    function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] row,
                                                  input logic [CW-1:0] col);
        return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
    endfunction

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            c_we      <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_addr    <= '0;
        end else begin
            // strobes live for one cycle after the tick edge that enters their state
            done      <= 1'b0;
            rd_en     <= 1'b0;
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            c_we      <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                i      <= '0;
                j      <= '0;
                k      <= '0;
                busy   <= 1'b0;
                a_addr <= '0;
                b_addr <= '0;
                c_addr <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= CLEAR;
                            i         <= '0;
                            j         <= '0;
                            k         <= '0;
                            busy      <= 1'b1;
                            mac_clear <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state  <= READ;
                        rd_en  <= 1'b1;
                        a_addr <= addr_of(i, k);
                        b_addr <= addr_of(k, j);
                    end
                    READ: begin
                        mac_en <= 1'b1;
                        if (k == LAST) begin
                            state <= DRAIN;
                        end else begin
                            k      <= k_inc;
                            rd_en  <= 1'b1;
                            a_addr <= addr_of(i, k_inc);
                            b_addr <= addr_of(k_inc, j);
                        end
                    end
                    DRAIN: begin
                        state  <= WRITE;
                        c_we   <= 1'b1;
                        c_addr <= addr_of(i, j);
                    end
                    WRITE: begin
                        if (i == LAST && j == LAST) begin
                            state  <= IDLE;
                            i      <= '0;
                            j      <= '0;
                            k      <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            a_addr <= '0;
                            b_addr <= '0;
                            c_addr <= '0;
                        end else begin
                            state     <= CLEAR;
                            k         <= '0;
                            mac_clear <= 1'b1;
                            if (j == LAST) begin
                                j <= '0;
                                i <= i_inc;
                            end else begin
                                j <= j_inc;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
